// File: rtl/configurable_division_pkg.sv
// Shared constants, state type and helpers for the configurable divider.
package configurable_division_pkg;

  // Operating modes selected by cm_i
  localparam logic [1:0] CM_SINGLE8  = 2'b00;
  localparam logic [1:0] CM_DUAL8    = 2'b01;
  localparam logic [1:0] CM_SINGLE16 = 2'b10;
  localparam logic [1:0] CM_ILLEGAL  = 2'b11;

  // Restoring iterations per operation, one quotient bit per step
  localparam logic [4:0] ITER8  = 5'd8;
  localparam logic [4:0] ITER16 = 5'd16;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  // Number of restoring steps needed for a given mode
  function automatic logic [4:0] iter_count(input logic [1:0] cm);
    return (cm == CM_SINGLE16) ? ITER16 : ITER8;
  endfunction

endpackage

// File: rtl/configurable_division_step.sv
// One combinational restoring-division step of configurable width.
module division_step #(
  parameter int unsigned Width = 8
) (
  input  logic [Width-1:0] i_rem,
  input  logic             i_bit,
  input  logic [Width-1:0] i_divisor,
  output logic [Width-1:0] o_rem,
  output logic             o_qbit
);

  logic [Width:0]   w_shifted;
  logic [Width+1:0] w_diff;

  assign w_shifted = {i_rem, i_bit};
  // Extra guard bit so the borrow is visible even when the shifted remainder has its MSB set
  assign w_diff    = {1'b0, w_shifted} - {2'b00, i_divisor};

  // Keep the difference when the trial subtraction did not borrow, otherwise restore
  always_comb begin
    o_qbit = ~w_diff[Width+1];
    o_rem  = w_shifted[Width-1:0];
    if (o_qbit) begin
      o_rem = w_diff[Width-1:0];
    end
  end

endmodule

// File: rtl/configurable_division.sv
// Sequential restoring divider: single 8-bit, dual 8-bit or single 16-bit lanes.
module configurable_division
  import configurable_division_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic [1:0]  cm_i,
  input  logic [15:0] dividend_i,
  input  logic [15:0] divisor_i,
  output logic        ready_o,
  output logic [15:0] quotient_o,
  output logic [15:0] remainder_o,
  output logic [1:0]  div_by_zero_o,
  output logic        error_o,
  output logic        data_valid_o
);

  state_e      r_state;
  state_e      w_state_next;

  // r_acc shifts dividend bits out of its MSB and quotient bits into its LSB
  logic [15:0] r_acc;
  logic [15:0] r_prem;
  logic [15:0] r_div;
  logic [1:0]  r_mode;
  logic [4:0]  r_cnt;
  logic [1:0]  r_dbz_pend;

  logic [15:0] r_quotient;
  logic [15:0] r_remainder;
  logic [1:0]  r_dbz;
  logic        r_error;

  logic        w_accept;
  logic        w_illegal;
  logic        w_last;
  logic        w_is16;
  logic [1:0]  w_dbz_calc;

  logic [7:0]  w_lo_rem;
  logic        w_lo_q;
  logic [7:0]  w_hi_rem;
  logic        w_hi_q;
  logic [15:0] w_wide_rem;
  logic        w_wide_q;

  logic [15:0] w_acc_next;
  logic [15:0] w_prem_next;
  logic [15:0] w_q_result;
  logic [15:0] w_r_result;

  assign w_accept  = (r_state == StIdle) && enable_i;
  assign w_illegal = (cm_i == CM_ILLEGAL);
  assign w_last    = (r_cnt == 5'd1);
  assign w_is16    = (r_mode == CM_SINGLE16);

  division_step #(.Width(8)) u_step_lo (
    .i_rem     (r_prem[7:0]),
    .i_bit     (r_acc[7]),
    .i_divisor (r_div[7:0]),
    .o_rem     (w_lo_rem),
    .o_qbit    (w_lo_q)
  );

  division_step #(.Width(8)) u_step_hi (
    .i_rem     (r_prem[15:8]),
    .i_bit     (r_acc[15]),
    .i_divisor (r_div[15:8]),
    .o_rem     (w_hi_rem),
    .o_qbit    (w_hi_q)
  );

  division_step #(.Width(16)) u_step_wide (
    .i_rem     (r_prem),
    .i_bit     (r_acc[15]),
    .i_divisor (r_div),
    .o_rem     (w_wide_rem),
    .o_qbit    (w_wide_q)
  );

  // Select the 16-bit slice or the two independent byte slices for this step
  always_comb begin
    w_acc_next  = {r_acc[14:8], w_hi_q, r_acc[6:0], w_lo_q};
    w_prem_next = {w_hi_rem, w_lo_rem};
    if (w_is16) begin
      w_acc_next  = {r_acc[14:0], w_wide_q};
      w_prem_next = w_wide_rem;
    end
  end

  // Single 8-bit mode runs the idle upper slice on zeros, so its result is masked off
  always_comb begin
    w_q_result = w_acc_next;
    w_r_result = w_prem_next;
    if (r_mode == CM_SINGLE8) begin
      w_q_result = {8'h00, w_acc_next[7:0]};
      w_r_result = {8'h00, w_prem_next[7:0]};
    end
  end

  // Per-lane divide-by-zero detection on the incoming divisor
  always_comb begin
    w_dbz_calc = 2'b00;
    case (cm_i)
      CM_SINGLE8:  w_dbz_calc = {1'b0, divisor_i[7:0] == 8'h00};
      CM_DUAL8:    w_dbz_calc = {divisor_i[15:8] == 8'h00, divisor_i[7:0] == 8'h00};
      CM_SINGLE16: w_dbz_calc = {1'b0, divisor_i == 16'h0000};
      default:     w_dbz_calc = 2'b00;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (enable_i) begin
          w_state_next = w_illegal ? StDone : StCalc;
        end
      end
      StCalc: begin
        if (w_last) begin
          w_state_next = StDone;
        end
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Operand capture, iteration and result registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_acc       <= '0;
      r_prem      <= '0;
      r_div       <= '0;
      r_mode      <= CM_SINGLE8;
      r_cnt       <= '0;
      r_dbz_pend  <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= '0;
      r_error     <= 1'b0;
    end else if (w_accept) begin
      r_error <= w_illegal;
      r_dbz   <= 2'b00;
      if (w_illegal) begin
        r_quotient  <= '0;
        r_remainder <= '0;
      end else begin
        r_mode     <= cm_i;
        r_cnt      <= iter_count(cm_i);
        r_prem     <= '0;
        r_dbz_pend <= w_dbz_calc;
        if (cm_i == CM_SINGLE8) begin
          r_acc <= {8'h00, dividend_i[7:0]};
          r_div <= {8'h00, divisor_i[7:0]};
        end else begin
          r_acc <= dividend_i;
          r_div <= divisor_i;
        end
      end
    end else if (r_state == StCalc) begin
      r_acc  <= w_acc_next;
      r_prem <= w_prem_next;
      r_cnt  <= r_cnt - 5'd1;
      if (w_last) begin
        r_quotient  <= w_q_result;
        r_remainder <= w_r_result;
        r_dbz       <= r_dbz_pend;
      end
    end
  end

  assign ready_o       = (r_state == StIdle);
  assign data_valid_o  = (r_state == StDone);
  assign quotient_o    = r_quotient;
  assign remainder_o   = r_remainder;
  assign div_by_zero_o = r_dbz;
  assign error_o       = r_error;

endmodule

// File: doc/configurable_division.md
# configurable_division

Sequential unsigned divider that mirrors `configurable_multiplication`. It uses the same three operating modes: single 8-bit, two parallel 8-bit lanes, or single 16-bit. It sits beside the multiplier in the arithmetic datapath and exposes the same start/valid style handshake. It produces a quotient and a remainder per lane, using a restoring algorithm that retires one quotient bit per clock.

## Interface
Parameters:
- none; widths are fixed at 16-bit operands.

Ports:
- `clk_i`  in  1  system clock, rising edge.
- `reset_i`  in  1  asynchronous, active-high reset.
- `enable_i`  in  1  start request; sampled only while `ready_o`=1.
- `cm_i`  in  2  mode: 00 single 8-bit, 01 dual 8-bit, 10 single 16-bit, 11 illegal.
- `dividend_i`  in  16  dividend; captured on accept.
- `divisor_i`  in  16  divisor; captured on accept.
- `ready_o`  out  1  high in IDLE; the block can accept a request.
- `quotient_o`  out  16  quotient; the lane-1 quotient is in [15:8] in dual mode.
- `remainder_o`  out  16  remainder; the lane-1 remainder is in [15:8] in dual mode.
- `div_by_zero_o`  out  2  per-lane divide-by-zero flag. Bit 0 covers lane 0, or the whole result in 16-bit mode.
- `error_o`  out  1  illegal mode flag; valid with `data_valid_o`.
- `data_valid_o`  out  1  one-cycle pulse; all result outputs are valid in this cycle.

## Operation
- States: IDLE, CALC, DONE.
- IDLE → CALC on `enable_i`=1, if `cm_i`≠11.
  - Captures operands and mode.
  - Loads the iteration counter with N: 8 in modes 00 and 01, 16 in mode 10.
- IDLE → DONE on `enable_i`=1 with `cm_i`=11.
  - Quotient and remainder are 0; `error_o`=1.
- CALC:
  - Each cycle performs one restoring step per active lane.
  - Partial remainder shift-left, bring in the next dividend MSB, trial-subtract the divisor.
  - Keep the difference if it is non-negative; shift the quotient bit in.
  - Counter decrements; on the last step, transition to DONE.
- DONE:
  - `data_valid_o`=1 for exactly one cycle, then → IDLE.
- Mode 00:
  - Uses only `dividend_i[7:0]` and `divisor_i[7:0]`.
  - Upper bytes are ignored; outputs [15:8] are zero.
- Mode 01:
  - Lanes are fully independent; there is no borrow between bytes.
- Mode 10:
  - One 16-bit lane.
- Divide by zero, per lane:
  - Quotient is all ones at the lane width.
  - Remainder equals the lane dividend.
  - The corresponding `div_by_zero_o` bit is set.
  - Latency is unchanged.
- `enable_i` is ignored in CALC and DONE; operand or mode changes during CALC have no effect.
- Result outputs and flags hold their values until the next DONE.
  - `error_o` and `div_by_zero_o` are cleared on the next accept.

## Timing
- Reset values: IDLE, `ready_o`=1, and all other outputs 0.
- Accept edge E0, with `enable_i`=1 and `ready_o`=1:
  - `ready_o` drops in the cycle after E0.
  - The N iteration edges are E1..EN.
  - Results are registered at EN, with `data_valid_o`=1 in the cycle after EN.
  - Edge EN+1 returns the block to IDLE with `ready_o`=1.
- Latency from accept to valid is N+1 cycles: 9 in the 8-bit modes, 17 in 16-bit mode.
- Minimum accept-to-accept spacing is N+2 cycles.
- Illegal mode: `data_valid_o` is high in the cycle after E0.
- Reset asserted mid-operation:
  - Immediately, and asynchronously, forces IDLE and zeroes all outputs, including the counter.
  - `ready_o`=1 while in reset.
  - The first accept is possible on the first edge after release.

## Structure
- Package `configurable_division_pkg` holds:
  - mode constants `CM_SINGLE8`, `CM_DUAL8`, `CM_SINGLE16`, `CM_ILLEGAL`;
  - the state enum;
  - iteration counts `ITER8`=8 and `ITER16`=16.
- Sub-module `division_step`: combinational single restoring step.
  - Width parameter; inputs are the partial remainder, incoming bit and divisor; outputs are the next remainder and the quotient bit.
  - Instantiated as two 8-bit slices for modes 00 and 01, plus one 16-bit slice.
  - Alternatively, a split 16-bit slice with the carry cut at bit 8.
- Top level holds the FSM, counter, and operand/result registers.

## Test plan
- Mode 10, 50000/123: `quotient_o`=406, `remainder_o`=62, `div_by_zero_o`=00. `data_valid_o` pulses exactly 17 cycles after the accept edge, for one cycle.
- Mode 01, dividend 16'hC807, divisor 16'h0F02: `quotient_o`=16'h0D03, `remainder_o`=16'h0501, valid after 9 cycles.
- Mode 00, dividend 16'hFF64, divisor 16'hAA07:
  - `quotient_o`=16'h000E, `remainder_o`=16'h0002.
  - This confirms the upper bytes are ignored.
- Mode 01, 16'h1234 / 16'h0500:
  - `quotient_o`=16'h03FF, `remainder_o`=16'h0334.
  - `div_by_zero_o`=2'b01, `error_o`=0.
- Mode 10, reset asserted at cycle 5 of CALC:
  - Outputs go to 0 and `ready_o`=1 immediately, with no valid pulse.
  - A new 1000/10 request accepted after release yields quotient 100, remainder 0.
- Mode 11 request:
  - `data_valid_o` and `error_o` are high in the cycle after accept; results are 0.
  - `enable_i` held high during a CALC must not restart or corrupt a running 16-bit operation.
